cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/execute/memory control sequencer for the 8-bit core
// Optional feature macro: CYCLE_CNT_EN (saturating retired-instruction counter on instr_count)
module cpu_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             eq,
  input  logic             lt,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_LHB  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_STR  = 4'b0011;
  localparam logic [3:0] OP_LIM  = 4'b0100;
  localparam logic [3:0] OP_MVB  = 4'b0101;
  localparam logic [3:0] OP_MVF  = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SFT  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_INC  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1110;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;
  localparam logic [1:0] WB_MOVE = 2'b11;

  state_t     state, state_nxt;
  logic [3:0] op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PC_INC;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op_q)
          OP_ADD, OP_SUB, OP_SFT, OP_INC: begin
            reg_we = 1'b1;
            wb_sel = WB_ALU;
            pc_en  = 1'b1;
          end
          OP_MVB, OP_MVF: begin
            reg_we = 1'b1;
            wb_sel = WB_MOVE;
            pc_en  = 1'b1;
          end
          OP_LIM: begin
            reg_we = 1'b1;
            wb_sel = WB_IMM;
            pc_en  = 1'b1;
          end
          OP_LB, OP_LHB, OP_STR: begin
            state_nxt = S_MEM;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_sel = PC_JUMP;
          end
          // Each branch looks only at its own flag, so eq=lt=1 needs no priority.
          OP_BNE: begin
            pc_en  = 1'b1;
            pc_sel = !eq ? PC_BRANCH : PC_INC;
          end
          OP_BEQ: begin
            pc_en  = 1'b1;
            pc_sel = eq ? PC_BRANCH : PC_INC;
          end
          OP_BLT: begin
            pc_en  = 1'b1;
            pc_sel = lt ? PC_BRANCH : PC_INC;
          end
          OP_HALT: begin
            state_nxt = S_HALT;
          end
          default: begin
            // TBA behaves as a NOP.
            pc_en = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_we = (op_q == OP_STR);
        mem_re = (op_q != OP_STR);
        if (mem_ready) begin
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
          if (op_q != OP_STR) begin
            reg_we = 1'b1;
            wb_sel = WB_MEM;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef CYCLE_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = ((state == S_EXEC) || (state == S_MEM)) && (state_nxt == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
// Expected instr_count follows CYCLE_CNT_EN: saturating count when defined, 0 otherwise.
module tb_cpu_ctrl_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       opcode = 4'b0000;
  logic             eq = 1'b0;
  logic             lt = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ir_load;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             mem_re;
  logic             mem_we;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  // ir_load, pc_en, pc_sel[1:0], reg_we, wb_sel[1:0], mem_re, mem_we, halted
  logic [9:0] outs;
  assign outs = {ir_load, pc_en, pc_sel, reg_we, wb_sel, mem_re, mem_we, halted};

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  cpu_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .eq(eq), .lt(lt),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .mem_re(mem_re), .mem_we(mem_we),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_model();
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef CYCLE_CNT_EN
    return exp_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic start_core();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called while the DUT sits in FETCH; leaves it in EXEC.
  task automatic to_exec(input logic [3:0] op);
    opcode = op;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL reset_outs: got %b expected %b", outs, 10'b0); end
    n_cmp++;
    if (instr_count !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", instr_count); end
    tick();
    reset = 1'b0;
    exp_cnt = '0;
    tick();
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL idle_outs: got %b expected %b", outs, 10'b0); end
  endtask

  task automatic test_add();
    start_core();
    n_cmp++;
    if (outs !== 10'b1_0_00_0_00_0_0_0) begin n_bad++; $display("FAIL add_fetch: got %b expected %b", outs, 10'b1_0_00_0_00_0_0_0); end
    to_exec(4'b0111);
    opcode = 4'b1110;
    #1;
    n_cmp++;
    if (outs !== 10'b0_1_00_1_00_0_0_0) begin n_bad++; $display("FAIL add_exec: got %b expected %b", outs, 10'b0_1_00_1_00_0_0_0); end
    tick();
    retire_model();
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL add_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
    n_cmp++;
    if (outs !== 10'b1_0_00_0_00_0_0_0) begin n_bad++; $display("FAIL add_refetch: got %b expected %b", outs, 10'b1_0_00_0_00_0_0_0); end
  endtask

  task automatic test_load_wait();
    to_exec(4'b0000);
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL lb_exec: got %b expected %b", outs, 10'b0); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (outs !== 10'b0_0_00_0_00_1_0_0) begin n_bad++; $display("FAIL lb_wait%0d: got %b expected %b", i, outs, 10'b0_0_00_0_00_1_0_0); end
    end
    tick();
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 10'b0_1_00_1_01_1_0_0) begin n_bad++; $display("FAIL lb_ready: got %b expected %b", outs, 10'b0_1_00_1_01_1_0_0); end
    tick();
    mem_ready = 1'b0;
    retire_model();
    n_cmp++;
    if (outs !== 10'b1_0_00_0_00_0_0_0) begin n_bad++; $display("FAIL lb_refetch: got %b expected %b", outs, 10'b1_0_00_0_00_0_0_0); end
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL lb_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
  endtask

  task automatic test_branches();
    logic [3:0] ops  [4] = '{4'b1011, 4'b1010, 4'b1100, 4'b0010};
    logic [1:0] flags[4] = '{2'b10, 2'b10, 2'b11, 2'b00};
    logic [9:0] exps [4] = '{10'b0_1_01_0_00_0_0_0, 10'b0_1_00_0_00_0_0_0,
                            10'b0_1_01_0_00_0_0_0, 10'b0_1_10_0_00_0_0_0};
    for (int i = 0; i < 4; i++) begin
      {eq, lt} = flags[i];
      to_exec(ops[i]);
      n_cmp++;
      if (outs !== exps[i]) begin n_bad++; $display("FAIL branch_op%b: got %b expected %b", ops[i], outs, exps[i]); end
      tick();
      retire_model();
    end
    {eq, lt} = 2'b00;
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL branch_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
  endtask

  task automatic test_store_reset();
    mem_ready = 1'b1;
    to_exec(4'b0011);
    mem_ready = 1'b0;
    tick();
    n_cmp++;
    if (outs !== 10'b0_0_00_0_00_0_1_0) begin n_bad++; $display("FAIL str_mem: got %b expected %b", outs, 10'b0_0_00_0_00_0_1_0); end
    tick();
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL str_reset_outs: got %b expected %b", outs, 10'b0); end
    n_cmp++;
    if (instr_count !== '0) begin n_bad++; $display("FAIL str_reset_cnt: got %0d expected 0", instr_count); end
    #2;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL str_idle: got %b expected %b", outs, 10'b0); end
    start_core();
    to_exec(4'b0100);
    n_cmp++;
    if (outs !== 10'b0_1_00_1_10_0_0_0) begin n_bad++; $display("FAIL lim_exec: got %b expected %b", outs, 10'b0_1_00_1_10_0_0_0); end
    tick();
    retire_model();
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL lim_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
  endtask

  task automatic test_halt();
    to_exec(4'b1110);
    n_cmp++;
    if (outs !== 10'b0) begin n_bad++; $display("FAIL halt_exec: got %b expected %b", outs, 10'b0); end
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      tick();
      n_cmp++;
      if (outs !== 10'b0_0_00_0_00_0_0_1) begin n_bad++; $display("FAIL halt_hold%0d: got %b expected %b", i, outs, 10'b0_0_00_0_00_0_0_1); end
    end
    start = 1'b0;
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL halt_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = '0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      n_cmp++;
      if (ir_load !== 1'b1) begin n_bad++; $display("FAIL b2b_fetch%0d: got %b expected 1", i, ir_load); end
      to_exec(4'b0100);
      tick();
      retire_model();
    end
    start = 1'b0;
    n_cmp++;
    if (instr_count !== cnt_exp()) begin n_bad++; $display("FAIL b2b_cnt: got %0d expected %0d", instr_count, cnt_exp()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branches();
    test_store_reset();
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
